sram_cache_arbiter: RTL

- Parametrised successor to the single-SRAM dual-requester memory stage.
- Arbitrates instruction-fetch (IF) and execute (EX) accesses onto one asynchronous external SRAM, through an internal direct-mapped write-back cache.
- Uses explicit req/ack handshakes instead of token comparison, with configurable SRAM wait states and a cache flush operation.
- Sits between the pipeline IF/MEM stages and the board SRAM pins.

---
 rtl/sram_cache_arbiter_if.sv | 37 +++
 rtl/sram_cache_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_cache_arbiter_if.sv
// Pipeline-side handshake bundle for sram_cache_arbiter.
//   master: pipeline (IF fetch, EX load/store, flush control)
//   slave : the arbiter
// Signals:
//   if_req/if_addr      -> IF read request (held until if_ack)
//   if_ack/if_rdata     <- one-cycle done pulse, data held until next if_ack
//   ex_req/ex_we/ex_addr/ex_wdata -> EX request (held until ex_ack)
//   ex_ack/ex_rdata     <- one-cycle done pulse, data held until next ex_ack
//   flush               -> write back all dirty lines (sampled when idle)
//   flush_done          <- one-cycle pulse at flush end
interface sram_cache_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          ex_req;
    logic          ex_we;
    logic [AW-1:0] ex_addr;
    logic [DW-1:0] ex_wdata;
    logic          ex_ack;
    logic [DW-1:0] ex_rdata;
    logic          flush;
    logic          flush_done;

    modport master (
        output if_req, if_addr, ex_req, ex_we, ex_addr, ex_wdata, flush,
        input  if_ack, if_rdata, ex_ack, ex_rdata, flush_done
    );

    modport slave (
        input  if_req, if_addr, ex_req, ex_we, ex_addr, ex_wdata, flush,
        output if_ack, if_rdata, ex_ack, ex_rdata, flush_done
    );
endinterface

// File: rtl/sram_cache_arbiter.sv
// Arbitrates IF and EX accesses onto one asynchronous SRAM through a
// direct-mapped, write-back, write-allocate cache of one-word lines.
// Ports:
//   clk, rst      clock; synchronous active-low reset
//   bus           sram_cache_arbiter_if.slave (IF/EX req/ack, flush)
//   sram_addr     SRAM address
//   sram_data     SRAM data, driven only during writeback states
//   sram_oe_n     output enable (active-low)
//   sram_we_n     write enable (active-low)
//   sram_en_n     chip enable, low whenever out of reset
//   busy          high whenever the FSM is not idle
module sram_cache_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int IDX_BITS = 4,
    parameter int RD_WAIT  = 1,
    parameter int WR_WAIT  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_cache_arbiter_if.slave  bus,
    output logic [AW-1:0]        sram_addr,
    inout  wire  [DW-1:0]        sram_data,
    output logic                 sram_oe_n,
    output logic                 sram_we_n,
    output logic                 sram_en_n,
    output logic                 busy
);
    localparam int LINES = 1 << IDX_BITS;
    localparam int TW    = AW - IDX_BITS;
    localparam int MAXW  = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CW    = (MAXW > 1) ? $clog2(MAXW) : 1;
    localparam logic [CW-1:0] RD_LAST = CW'(RD_WAIT - 1);
    localparam logic [CW-1:0] WR_LAST = CW'(WR_WAIT - 1);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WB_SETUP   = 3'd1;
    localparam logic [2:0] ST_WB_PULSE   = 3'd2;
    localparam logic [2:0] ST_WB_HOLD    = 3'd3;
    localparam logic [2:0] ST_RD_ADDR    = 3'd4;
    localparam logic [2:0] ST_RD_WAIT    = 3'd5;
    localparam logic [2:0] ST_FILL       = 3'd6;
    localparam logic [2:0] ST_FLUSH_SCAN = 3'd7;

    logic [2:0]          state;
    logic [CW-1:0]       cnt;
    logic [LINES-1:0]    valid;
    logic [LINES-1:0]    dirty;
    logic [TW-1:0]       tag_mem  [LINES];
    logic [DW-1:0]       data_mem [LINES];

    logic                if_ack_q, ex_ack_q, flush_done_q;
    logic [DW-1:0]       if_rdata_q, ex_rdata_q;
    logic [AW-1:0]       addr_q;
    logic [DW-1:0]       wb_data;
    logic                en_n_q;
    logic [IDX_BITS-1:0] scan_idx;

    // Pending access captured when a miss leaves IDLE.
    logic                op_ex, op_we, op_flush;
    logic [AW-1:0]       op_addr;
    logic [DW-1:0]       op_wdata;
    logic [IDX_BITS-1:0] op_idx;
    logic [TW-1:0]       op_tag;

    logic                sel_ex, sel_if, req_we, req_hit;
    logic [AW-1:0]       req_addr;
    logic [IDX_BITS-1:0] req_idx;
    logic [TW-1:0]       req_tag;

    // A requester whose ack is high this cycle is ignored, so a held req
    // is only taken as a new access one cycle later.
    always_comb begin
        sel_ex   = bus.ex_req && !ex_ack_q;
        sel_if   = bus.if_req && !if_ack_q && !sel_ex;
        req_addr = sel_ex ? bus.ex_addr : bus.if_addr;
        req_we   = sel_ex && bus.ex_we;
    end

    assign req_idx = req_addr[IDX_BITS-1:0];
    assign req_tag = req_addr[AW-1:IDX_BITS];
    assign req_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign op_idx  = op_addr[IDX_BITS-1:0];
    assign op_tag  = op_addr[AW-1:IDX_BITS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            valid        <= '0;
            dirty        <= '0;
            if_ack_q     <= 1'b0;
            ex_ack_q     <= 1'b0;
            flush_done_q <= 1'b0;
            if_rdata_q   <= '0;
            ex_rdata_q   <= '0;
            addr_q       <= '0;
            wb_data      <= '0;
            en_n_q       <= 1'b1;
            scan_idx     <= '0;
            op_ex        <= 1'b0;
            op_we        <= 1'b0;
            op_flush     <= 1'b0;
            op_addr      <= '0;
            op_wdata     <= '0;
        end else begin
            en_n_q       <= 1'b0;
            if_ack_q     <= 1'b0;
            ex_ack_q     <= 1'b0;
            flush_done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.flush && !flush_done_q) begin
                        op_flush <= 1'b1;
                        scan_idx <= '0;
                        state    <= ST_FLUSH_SCAN;
                    end else if (sel_ex || sel_if) begin
                        op_ex    <= sel_ex;
                        op_we    <= req_we;
                        op_addr  <= req_addr;
                        op_wdata <= bus.ex_wdata;
                        if (req_hit) begin
                            if (req_we) begin
                                data_mem[req_idx] <= bus.ex_wdata;
                                dirty[req_idx]    <= 1'b1;
                                ex_ack_q          <= 1'b1;
                            end else if (sel_ex) begin
                                ex_rdata_q <= data_mem[req_idx];
                                ex_ack_q   <= 1'b1;
                            end else begin
                                if_rdata_q <= data_mem[req_idx];
                                if_ack_q   <= 1'b1;
                            end
                        end else if (valid[req_idx] && dirty[req_idx]) begin
                            addr_q  <= {tag_mem[req_idx], req_idx};
                            wb_data <= data_mem[req_idx];
                            state   <= ST_WB_SETUP;
                        end else if (req_we) begin
                            // One-word lines: write-allocate needs no fetch.
                            tag_mem[req_idx]  <= req_tag;
                            data_mem[req_idx] <= bus.ex_wdata;
                            valid[req_idx]    <= 1'b1;
                            dirty[req_idx]    <= 1'b1;
                            ex_ack_q          <= 1'b1;
                            state             <= ST_FILL;
                        end else begin
                            addr_q <= req_addr;
                            state  <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WB_SETUP: begin
                    cnt   <= '0;
                    state <= ST_WB_PULSE;
                end
                ST_WB_PULSE: begin
                    if (cnt == WR_LAST) begin
                        state <= ST_WB_HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WB_HOLD: begin
                    if (op_flush) begin
                        dirty[scan_idx] <= 1'b0;
                        if (scan_idx == '1) begin
                            op_flush     <= 1'b0;
                            flush_done_q <= 1'b1;
                            state        <= ST_IDLE;
                        end else begin
                            scan_idx <= scan_idx + 1'b1;
                            state    <= ST_FLUSH_SCAN;
                        end
                    end else if (op_we) begin
                        tag_mem[op_idx]  <= op_tag;
                        data_mem[op_idx] <= op_wdata;
                        valid[op_idx]    <= 1'b1;
                        dirty[op_idx]    <= 1'b1;
                        ex_ack_q         <= 1'b1;
                        state            <= ST_FILL;
                    end else begin
                        addr_q <= op_addr;
                        state  <= ST_RD_ADDR;
                    end
                end
                ST_RD_ADDR: begin
                    cnt   <= '0;
                    state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (cnt == RD_LAST) begin
                        // Sampled at the end of the last wait cycle; ack is
                        // then high during FILL.
                        tag_mem[op_idx]  <= op_tag;
                        data_mem[op_idx] <= sram_data;
                        valid[op_idx]    <= 1'b1;
                        dirty[op_idx]    <= 1'b0;
                        if (op_ex) begin
                            ex_rdata_q <= sram_data;
                            ex_ack_q   <= 1'b1;
                        end else begin
                            if_rdata_q <= sram_data;
                            if_ack_q   <= 1'b1;
                        end
                        state <= ST_FILL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_FILL: begin
                    state <= ST_IDLE;
                end
                ST_FLUSH_SCAN: begin
                    if (valid[scan_idx] && dirty[scan_idx]) begin
                        addr_q  <= {tag_mem[scan_idx], scan_idx};
                        wb_data <= data_mem[scan_idx];
                        state   <= ST_WB_SETUP;
                    end else if (scan_idx == '1) begin
                        op_flush     <= 1'b0;
                        flush_done_q <= 1'b1;
                        state        <= ST_IDLE;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Strobes decode from the registered state, so a reset edge returns
    // we_n/oe_n high and releases the data bus immediately.
    logic drive_data;
    assign drive_data = (state == ST_WB_SETUP) || (state == ST_WB_PULSE) ||
                        (state == ST_WB_HOLD);
    assign sram_data  = drive_data ? wb_data : 'z;
    assign sram_oe_n  = !((state == ST_RD_ADDR) || (state == ST_RD_WAIT));
    assign sram_we_n  = (state != ST_WB_PULSE);
    assign sram_en_n  = en_n_q;
    assign sram_addr  = addr_q;
    assign busy       = (state != ST_IDLE);

    assign bus.if_ack     = if_ack_q;
    assign bus.ex_ack     = ex_ack_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.ex_rdata   = ex_rdata_q;
    assign bus.flush_done = flush_done_q;
endmodule
